ifetch_unit: RTL and testbench
==============================

# ifetch_unit

- Instruction fetch front end and requester side of the instruction memory interface.
- Drives word addresses into the byte-wide instruction memory and tracks that memory's fixed two-cycle read latency with in-flight tags.
- Buffers returned words in a small FIFO and hands `{pc, inst}` to decode over a valid/ready handshake.
- Sits between the pipeline's PC-redirect logic (branch/jump/trap) and the decode stage.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 4: output buffer entries. Must be a power of two and ≥2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `imem_addr` output 32: fetch address to the instruction memory; always equals the internal `pc` register.
- `imem_data` input 32: instruction memory read data, valid two cycles after its address.
- `redirect_valid` input 1: flush and restart fetch.
- `redirect_pc` input 32: new fetch address.
- `out_valid` output 1: FIFO head entry available.
- `out_ready` input 1: decode accepts the head entry.
- `out_inst` output 32: head instruction.
- `out_pc` output 32: address of the head instruction.
- `out_fault` output 1: head entry is a fetch fault (misaligned target). Tied 0 unless the macro in Configuration is defined.

## Operation
- **Reset values:** `pc` = `RESET_PC`, so `imem_addr` = `RESET_PC`. `out_valid` = 0, `out_inst` = 0, `out_pc` = 0, `out_fault` = 0. Tags invalid, FIFO empty, state `RUN`.
- **Issue rule:** in `RUN`, an issue occurs when `fifo_count + inflight_count < FIFO_DEPTH`. A pop in the same cycle is not credited.
  - On an issue, tag stage T1 captures `{1, pc}` and `pc` advances by 4 (mod 2^32; `32'hFFFF_FFFC` wraps to 0).
  - With no issue, `pc` holds and T1 captures valid = 0.
- **Tag pipeline:** T2 <= T1 every cycle. When T2 is valid, `{imem_data, T2.pc, fault=0}` is pushed into the FIFO.
  - The credit rule guarantees the push never overflows.
- **Pop:** `out_valid && out_ready` removes the head entry.
  - A simultaneous push and pop leaves the count unchanged.
- **Redirect** (highest priority, applied at the clock edge):
  - FIFO flushed, T1/T2 invalidated, `pc` <= `redirect_pc`, state <= `RUN`.
  - A handshake in the redirect cycle is killed: the consumer discards it.
  - Data returning for killed tags is dropped.
  - No issue occurs in the redirect cycle.
- **States:** `RUN`, `FAULT`, `HALT`. `FAULT` and `HALT` exist only with the macro.
  - `FAULT` -> `HALT` when the fault entry is accepted.
  - `HALT` leaves only on a redirect.

## Timing
- **Issue latency:** address issued in cycle c, then `imem_data` valid in cycle c+2, then pushed at the end of c+2, then `out_valid` in c+3.
- **After reset deassert:** first issue in cycle 0, first `out_valid` in cycle 3 with `out_pc` = `RESET_PC`.
- **After redirect:** redirect in cycle r, issue of `redirect_pc` in r+1, `out_valid` with `out_pc` = `redirect_pc` in r+4.
- **Throughput:** sustained one instruction per cycle with `out_ready` held high and `FIFO_DEPTH` ≥4.
- **Backpressure:** with `out_ready` = 0, issue stops once FIFO plus in-flight tags reach `FIFO_DEPTH`. No word is lost or duplicated.
- **Outputs:** `out_*` are driven from FIFO head registers. There is no combinational path from `imem_data` to `out_*`.
- **Reset mid-operation:** asynchronous return to the reset values in the same cycle. In-flight data is dropped.

## Configuration
- **`IFETCH_MISALIGN_TRAP_EN` undefined:**
  - `redirect_pc[1:0]` is ignored (forced to 00).
  - `out_fault` = 0; states `FAULT`/`HALT` are absent.
- **`IFETCH_MISALIGN_TRAP_EN` defined:** a redirect with `redirect_pc[1:0]` != 0 flushes as normal, then enters `FAULT`.
  - In `FAULT`, no issue occurs. The FIFO receives one entry `{inst=32'h0000_0013, pc=redirect_pc, fault=1}` in the cycle after the redirect.
  - After that entry is accepted the state is `HALT`: no issue, `out_valid` = 0, until the next redirect.

## Test plan
- **Reset/boot:** `RESET_PC`=0x100, memory words 0x11,0x22,0x33 at 0x100/0x104/0x108, `out_ready`=1. Expect `out_valid` first in cycle 3, then (0x100,0x11), (0x104,0x22), (0x108,0x33) on consecutive cycles.
- **Backpressure:** `out_ready`=0 for 10 cycles, then 1. Expect at most 4 issues during the stall and FIFO count 4. After release, addresses appear strictly increasing by 4 with no gap, loss or duplication.
- **Redirect flush:** redirect to 0x200 while 2 tags are in flight and the FIFO is non-empty. Expect no stale output; the first output is 0x200 exactly 4 cycles after the redirect.
- **Redirect coinciding with handshake, plus back-to-back redirects:**
  - Redirect while `out_valid && out_ready`: the beat is killed.
  - Redirects to 0x300 then 0x400 in consecutive cycles: only 0x400-stream entries appear.
- **Wrap:** redirect to 0xFFFF_FFF8. Expect `out_pc` 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Macro defined, misaligned redirect:** redirect to 0x202. Expect one entry with `out_fault`=1, `out_pc`=0x202, `out_inst`=0x13. `imem_addr` then holds and `out_valid` stays 0 until a redirect to 0x300, which resumes normal fetch.

Source files
------------

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Purpose  : Instruction fetch front end with a two-cycle memory tag pipeline and
//            an output FIFO. Optional misaligned-redirect trap: IFETCH_MISALIGN_TRAP_EN
// Revision : 1.0
// ============================================================================
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        out_fault
);

   localparam int             PTR_W     = $clog2(FIFO_DEPTH);
   localparam int             CNT_W     = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

   logic [31:0]      pc_q, pc_d;
   logic             t1_vld_q, t1_vld_d;
   logic [31:0]      t1_pc_q, t1_pc_d;
   logic             t2_vld_q, t2_vld_d;
   logic [31:0]      t2_pc_q, t2_pc_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      fifo_inst_q [FIFO_DEPTH];
   logic [31:0]      fifo_inst_d [FIFO_DEPTH];
   logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
   logic [31:0]      fifo_pc_d   [FIFO_DEPTH];

   logic             run_mode;
   logic             fault_push;
   logic             issue;
   logic             push;
   logic             pop;
   logic [31:0]      redir_pc;
   logic [31:0]      push_inst;
   logic [31:0]      push_pc;
   logic [CNT_W:0]   occupancy;

   // Credit counts buffered plus in-flight words; a same-cycle pop is not credited.
   assign occupancy = {1'b0, count_q} + (CNT_W + 1)'(t1_vld_q) + (CNT_W + 1)'(t2_vld_q);
   assign issue     = run_mode && !redirect_valid && (occupancy < DEPTH_OCC);
   assign pop       = out_valid && out_ready && !redirect_valid;
   assign push      = (t2_vld_q || fault_push) && !redirect_valid;

   assign imem_addr = pc_q;
   assign out_valid = (count_q != '0);
   assign out_inst  = fifo_inst_q[rd_ptr_q];
   assign out_pc    = fifo_pc_q[rd_ptr_q];

`ifdef IFETCH_MISALIGN_TRAP_EN
   localparam logic [31:0] FAULT_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FAULT = 2'd1,
      HALT  = 2'd2
   } state_e;

   state_e state_q, state_d;
   logic   fifo_fault_q [FIFO_DEPTH];
   logic   fifo_fault_d [FIFO_DEPTH];

   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
      end else if ((state_q == FAULT) && pop) begin
         state_d = HALT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // The FIFO is empty only before the fault entry has been written.
   assign run_mode   = (state_q == RUN);
   assign fault_push = (state_q == FAULT) && (count_q == '0);
   assign redir_pc   = redirect_pc;
   assign push_inst  = fault_push ? FAULT_INST : imem_data;
   assign push_pc    = fault_push ? pc_q : t2_pc_q;

   always_comb begin
      fifo_fault_d = fifo_fault_q;
      if (push) begin
         fifo_fault_d[wr_ptr_q] = fault_push;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_fault_q <= '{default: 1'b0};
      end else begin
         fifo_fault_q <= fifo_fault_d;
      end
   end

   assign out_fault = fifo_fault_q[rd_ptr_q];
`else
   logic unused_redirect_lsb;

   assign run_mode            = 1'b1;
   assign fault_push          = 1'b0;
   assign redir_pc            = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsb = ^redirect_pc[1:0];
   assign push_inst           = imem_data;
   assign push_pc             = t2_pc_q;
   assign out_fault           = 1'b0;
`endif

   always_comb begin
      pc_d        = pc_q;
      t1_vld_d    = issue;
      t1_pc_d     = pc_q;
      t2_vld_d    = t1_vld_q;
      t2_pc_d     = t1_pc_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      fifo_inst_d = fifo_inst_q;
      fifo_pc_d   = fifo_pc_q;

      if (issue) begin
         pc_d = pc_q + 32'd4;
      end
      if (push) begin
         fifo_inst_d[wr_ptr_q] = push_inst;
         fifo_pc_d[wr_ptr_q]   = push_pc;
         wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      // Redirect wins: flush buffer and tags so late memory data is dropped.
      if (redirect_valid) begin
         pc_d     = redir_pc;
         t1_vld_d = 1'b0;
         t2_vld_d = 1'b0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         t1_vld_q    <= 1'b0;
         t1_pc_q     <= '0;
         t2_vld_q    <= 1'b0;
         t2_pc_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         fifo_inst_q <= '{default: '0};
         fifo_pc_q   <= '{default: '0};
      end else begin
         pc_q        <= pc_d;
         t1_vld_q    <= t1_vld_d;
         t1_pc_q     <= t1_pc_d;
         t2_vld_q    <= t2_vld_d;
         t2_pc_q     <= t2_pc_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         fifo_inst_q <= fifo_inst_d;
         fifo_pc_q   <= fifo_pc_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// Testbench for ifetch_unit: directed scenarios plus a randomized run, checked
// against an expected-address stream and a two-cycle-latency memory model.
module tb_ifetch_unit;

   localparam logic [31:0] BOOT_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_fault;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_pc;

   ifetch_unit #(
      .RESET_PC  (BOOT_PC),
      .FIFO_DEPTH(4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst      (out_inst),
      .out_pc        (out_pc),
      .out_fault     (out_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'h0000_0011;
         32'h0000_0104: return 32'h0000_0022;
         32'h0000_0108: return 32'h0000_0033;
         default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   // Memory: data for the address presented in cycle c appears in cycle c+2.
   logic [31:0] mem_a1 = '0;
   logic [31:0] mem_a2 = '0;
   always @(posedge clk) begin
      mem_a1 <= imem_addr;
      mem_a2 <= mem_a1;
   end
   assign imem_data = memf(mem_a2);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] boot_inst [3];
      boot_inst = '{32'h11, 32'h22, 32'h33};
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) tick();
      checks++;
      if (imem_addr !== BOOT_PC) begin
         errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, BOOT_PC);
      end
      checks++;
      if (out_valid !== 1'b0 || out_fault !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got v=%b f=%b expected 0 0", out_valid, out_fault);
      end
      checks++;
      if (out_inst !== 32'h0 || out_pc !== 32'h0) begin
         errors++; $display("FAIL reset_data: got inst=%h pc=%h expected 0 0", out_inst, out_pc);
      end
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL boot_early: got valid=%b in cycle 2 expected 0", out_valid);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== BOOT_PC + 32'(4 * k) || out_inst !== boot_inst[k]) begin
            errors++;
            $display("FAIL boot_beat%0d: got v=%b pc=%h inst=%h expected 1 %h %h",
                     k, out_valid, out_pc, out_inst, BOOT_PC + 32'(4 * k), boot_inst[k]);
         end
      end
      exp_pc = BOOT_PC + 32'd12;
   endtask

   task automatic test_stream();
      for (int k = 0; k < 8; k++) begin
         tick();
         out_ready = 1'b1;
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== memf(exp_pc)) begin
            errors++;
            $display("FAIL stream: got v=%b pc=%h inst=%h expected 1 %h %h",
                     out_valid, out_pc, out_inst, exp_pc, memf(exp_pc));
         end
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] prev;
      int          issues;
      int          late_issues;
      issues = 0;
      late_issues = 0;
      tick();
      out_ready = 1'b0;
      prev = imem_addr;
      for (int k = 1; k < 10; k++) begin
         tick();
         out_ready = 1'b0;
         if (imem_addr !== prev) begin
            issues++;
            if (k >= 6) late_issues++;
         end
         prev = imem_addr;
      end
      checks++;
      if (issues > 4 || late_issues != 0) begin
         errors++; $display("FAIL stall_issues: got %0d (late %0d) expected <=4 (late 0)", issues, late_issues);
      end
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
         errors++; $display("FAIL stall_head: got v=%b pc=%h expected 1 %h", out_valid, out_pc, exp_pc);
      end
      // With four buffered words and nothing in flight, fetch sits four words past the head.
      checks++;
      if (imem_addr !== exp_pc + 32'd16) begin
         errors++; $display("FAIL stall_fill: got addr=%h expected %h", imem_addr, exp_pc + 32'd16);
      end
      for (int k = 0; k < 12; k++) begin
         if (k != 0) tick();
         out_ready = 1'b1;
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== memf(exp_pc)) begin
            errors++;
            $display("FAIL release: got v=%b pc=%h inst=%h expected 1 %h %h",
                     out_valid, out_pc, out_inst, exp_pc, memf(exp_pc));
         end
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic test_redirect_flush();
      tick();
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL flush_pre: got valid=%b expected 1", out_valid);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         redirect_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_stale: got valid=%b pc=%h at r+%0d expected 0", out_valid, out_pc, k);
         end
      end
      exp_pc = 32'h0000_0200;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== memf(exp_pc)) begin
            errors++;
            $display("FAIL flush_new: got v=%b pc=%h inst=%h expected 1 %h %h",
                     out_valid, out_pc, out_inst, exp_pc, memf(exp_pc));
         end
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic test_back_to_back();
      logic found;
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         out_ready = 1'b1;
         if (out_valid) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL b2b_wait: got no valid beat expected one within 10 cycles");
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0300;
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0400;
      for (int k = 1; k <= 3; k++) begin
         tick();
         redirect_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_stale: got valid=%b pc=%h at r+%0d expected 0", out_valid, out_pc, k);
         end
      end
      exp_pc = 32'h0000_0400;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== memf(exp_pc)) begin
            errors++;
            $display("FAIL b2b_stream: got v=%b pc=%h inst=%h expected 1 %h %h",
                     out_valid, out_pc, out_inst, exp_pc, memf(exp_pc));
         end
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic test_wrap();
      tick();
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      repeat (3) begin
         tick();
         redirect_valid = 1'b0;
      end
      exp_pc = 32'hFFFF_FFF8;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== memf(exp_pc)) begin
            errors++;
            $display("FAIL wrap: got v=%b pc=%h inst=%h expected 1 %h %h",
                     out_valid, out_pc, out_inst, exp_pc, memf(exp_pc));
         end
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic test_misalign();
`ifdef IFETCH_MISALIGN_TRAP_EN
      logic found;
      found = 1'b0;
      tick();
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0202;
      for (int k = 0; k < 6; k++) begin
         tick();
         redirect_valid = 1'b0;
         out_ready = 1'b0;
         if (out_valid) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL fault_wait: got no entry expected fault entry within 6 cycles");
      end
      checks++;
      if (out_fault !== 1'b1 || out_pc !== 32'h0000_0202 || out_inst !== 32'h0000_0013) begin
         errors++;
         $display("FAIL fault_entry: got f=%b pc=%h inst=%h expected 1 00000202 00000013",
                  out_fault, out_pc, out_inst);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || imem_addr !== 32'h0000_0202) begin
            errors++; $display("FAIL halt: got v=%b addr=%h expected 0 00000202", out_valid, imem_addr);
         end
      end
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0300;
      repeat (3) begin
         tick();
         redirect_valid = 1'b0;
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0000_0300 || out_fault !== 1'b0) begin
         errors++; $display("FAIL resume: got v=%b pc=%h f=%b expected 1 00000300 0", out_valid, out_pc, out_fault);
      end
      exp_pc = 32'h0000_0304;
`else
      tick();
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0202;
      repeat (3) begin
         tick();
         redirect_valid = 1'b0;
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0000_0200 || out_fault !== 1'b0) begin
         errors++; $display("FAIL misalign_ignored: got v=%b pc=%h f=%b expected 1 00000200 0", out_valid, out_pc, out_fault);
      end
      exp_pc = 32'h0000_0204;
`endif
   endtask

   task automatic test_reset_midop();
      tick();
      out_ready = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem_addr !== BOOT_PC || out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: got addr=%h v=%b pc=%h inst=%h expected %h 0 0 0",
                  imem_addr, out_valid, out_pc, out_inst, BOOT_PC);
      end
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reboot_early: got valid=%b expected 0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== BOOT_PC || out_inst !== 32'h11) begin
         errors++; $display("FAIL reboot: got v=%b pc=%h inst=%h expected 1 %h 00000011", out_valid, out_pc, out_inst, BOOT_PC);
      end
      exp_pc = BOOT_PC + 32'd4;
   endtask

   task automatic test_random();
      logic [31:0] r;
      int          since_redir;
      int          beats;
      since_redir = 100;
      beats = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         since_redir++;
         if (since_redir >= 1 && since_redir <= 3) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++; $display("FAIL rand_early: got valid=%b pc=%h at r+%0d expected 0", out_valid, out_pc, since_redir);
            end
         end
         r = $urandom;
         redirect_valid = ($urandom_range(0, 19) == 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
         redirect_pc = r & 32'hFFFF_FFFC;
`else
         redirect_pc = r;
`endif
         out_ready = ($urandom_range(0, 3) != 0);
         if (redirect_valid) begin
            exp_pc = r & 32'hFFFF_FFFC;
            since_redir = 0;
         end else if (out_valid && out_ready) begin
            checks++;
            beats++;
            if (out_pc !== exp_pc || out_inst !== memf(exp_pc) || out_fault !== 1'b0) begin
               errors++;
               $display("FAIL rand_beat: got pc=%h inst=%h f=%b expected %h %h 0",
                        out_pc, out_inst, out_fault, exp_pc, memf(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
      end
      redirect_valid = 1'b0;
      checks++;
      if (beats < 100) begin
         errors++; $display("FAIL rand_progress: got %0d beats expected at least 100", beats);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_flush();
      test_back_to_back();
      test_wrap();
      test_misalign();
      test_reset_midop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
